// File: rtl/prog_loader_pkg.sv
// Shared types and default widths for the program loader.
//   ldr_state_t : loader sequencing states
//   ldr_err_t   : error codes reported on err_code
package prog_loader_pkg;

  localparam int unsigned DefD       = 12;    // instruction-memory address width
  localparam int unsigned DefW       = 9;     // machine-code word width
  localparam int unsigned DefTimeout = 4096;  // RUN-cycle budget
  localparam int unsigned DefCw      = 16;    // cycle-counter width

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLaunch,
    StRun,
    StFinish,
    StError
  } ldr_state_t;

  typedef enum logic [1:0] {
    ErrNone    = 2'd0,
    ErrOvf     = 2'd1,
    ErrTimeout = 2'd2,
    ErrChk     = 2'd3
  } ldr_err_t;

endpackage

// File: rtl/prog_loader_run_timer.sv
// run_timer: saturating cycle counter for the RUN phase.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear (wins over en)
//   en         : count this cycle
//   count      : current count
//   limit_hit  : this enabled cycle brings the count to LIMIT
module run_timer
  import prog_loader_pkg::*;
#(
  parameter int unsigned CW    = DefCw,
  parameter int unsigned LIMIT = DefTimeout
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          limit_hit
);

  localparam logic [CW-1:0] Limit = CW'(LIMIT);

  logic [CW-1:0] count_q, count_d, count_inc;

  // Saturate at all-ones instead of wrapping.
  assign count_inc = (&count_q) ? count_q : count_q + 1'b1;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flags the cycle that completes the budget, so the count shows exactly LIMIT afterwards.
  assign limit_hit = en && (count_inc == Limit);
  assign count     = count_q;

endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams a program into the core's instruction memory, launches the core
// and supervises its run.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to add the ld_chk input and an XOR
// checksum check on the last word (error code 3 on mismatch).
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   start                           : begin a new load (honoured in IDLE/FINISH/ERROR)
//   ld_valid/ld_ready/ld_data/ld_last : program word stream
//   ld_chk                          : expected checksum (checksum build only)
//   im_wr_en/im_addr/im_wr_data     : instruction-memory write port, one cycle after accept
//   core_reset/core_req/core_done   : core control
//   busy/run_done/err/err_code      : status
//   prog_len/cycles                 : words loaded, RUN cycles
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned D       = DefD,
  parameter int unsigned W       = DefW,
  parameter int unsigned TIMEOUT = DefTimeout,
  parameter int unsigned CW      = DefCw
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [W-1:0]  ld_data,
  input  logic          ld_last,
`ifdef PROG_LOADER_CHECKSUM_EN
  input  logic [W-1:0]  ld_chk,
`endif
  output logic          im_wr_en,
  output logic [D-1:0]  im_addr,
  output logic [W-1:0]  im_wr_data,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          busy,
  output logic          run_done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [D:0]    prog_len,
  output logic [CW-1:0] cycles
);

  localparam logic [D:0] LastAddr = {1'b0, {D{1'b1}}};

  ldr_state_t    state_q, state_d;
  ldr_err_t      err_code_q, err_code_d;
  logic [D:0]    len_q, len_d;
  logic          wr_en_q;
  logic [D-1:0]  addr_q;
  logic [W-1:0]  data_q;
  logic          accept;
  logic          start_load;
  logic          chk_fail;
  logic          run_en;
  logic          limit_hit;
  logic [CW-1:0] cycle_count;

  assign accept = (state_q == StLoad) && ld_valid;
  assign run_en = (state_q == StRun);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [W-1:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (start_load) begin
      chk_d = '0;
    end else if (accept) begin
      chk_d = chk_q ^ ld_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign chk_fail = ((chk_q ^ ld_data) != ld_chk);
`else
  assign chk_fail = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    err_code_d = err_code_q;
    start_load = 1'b0;
    unique case (state_q)
      StIdle, StFinish, StError: begin
        if (start) begin
          state_d    = StLoad;
          len_d      = '0;
          err_code_d = ErrNone;
          start_load = 1'b1;
        end
      end
      StLoad: begin
        if (accept) begin
          len_d = len_q + 1'b1;
          // Overflow only when the top address is filled without last, so it cannot
          // coincide with a checksum failure; checked first regardless.
          if (!ld_last && (len_q == LastAddr)) begin
            state_d    = StError;
            err_code_d = ErrOvf;
          end else if (ld_last && chk_fail) begin
            state_d    = StError;
            err_code_d = ErrChk;
          end else if (ld_last) begin
            state_d = StLaunch;
          end
        end
      end
      StLaunch: state_d = StRun;
      StRun: begin
        if (core_done) begin
          state_d = StFinish;
        end else if (limit_hit) begin
          state_d    = StError;
          err_code_d = ErrTimeout;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      err_code_q <= ErrNone;
      len_q      <= '0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      len_q      <= len_d;
      wr_en_q    <= accept;
      if (accept) begin
        addr_q <= len_q[D-1:0];
        data_q <= ld_data;
      end
    end
  end

  run_timer #(
    .CW   (CW),
    .LIMIT(TIMEOUT)
  ) u_run_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (start_load),
    .en       (run_en),
    .count    (cycle_count),
    .limit_hit(limit_hit)
  );

  // All outputs come from registers; core_reset is high in every state except RUN/FINISH,
  // so the reset state (IDLE) holds the core in reset immediately.
  assign ld_ready   = (state_q == StLoad);
  assign core_reset = !((state_q == StRun) || (state_q == StFinish));
  // The timer is cleared on start and only counts in RUN, so zero marks the first RUN cycle.
  assign core_req   = (state_q == StRun) && (cycle_count == '0);
  assign busy       = (state_q == StLoad) || (state_q == StLaunch) || (state_q == StRun);
  assign run_done   = (state_q == StFinish);
  assign err        = (state_q == StError);
  assign err_code   = err_code_q;
  assign im_wr_en   = wr_en_q;
  assign im_addr    = addr_q;
  assign im_wr_data = data_q;
  assign prog_len   = len_q;
  assign cycles     = cycle_count;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader (D=3, TIMEOUT=20). The driver pushes the expected
// memory writes and the expected end-of-run status; a monitor pops and compares them
// whenever the DUT writes or raises run_done/err.
module tb_prog_loader;

  localparam int unsigned D  = 3;
  localparam int unsigned W  = 9;
  localparam int unsigned TO = 20;
  localparam int unsigned CW = 16;

  typedef struct packed {
    logic [D-1:0] addr;
    logic [W-1:0] data;
  } wr_t;

  typedef struct packed {
    logic          is_err;
    logic [1:0]    code;
    logic [CW-1:0] cyc;
    logic [D:0]    len;
  } res_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          ld_valid;
  logic          ld_ready;
  logic [W-1:0]  ld_data;
  logic          ld_last;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [W-1:0]  ld_chk;
`endif
  logic          im_wr_en;
  logic [D-1:0]  im_addr;
  logic [W-1:0]  im_wr_data;
  logic          core_reset;
  logic          core_req;
  logic          core_done;
  logic          busy;
  logic          run_done;
  logic          err;
  logic [1:0]    err_code;
  logic [D:0]    prog_len;
  logic [CW-1:0] cycles;

  wr_t  wq[$];
  res_t rq[$];
  logic [W-1:0] prog [8];
  int   checks   = 0;
  int   failures = 0;
  int   req_cnt  = 0;

  prog_loader #(
    .D      (D),
    .W      (W),
    .TIMEOUT(TO),
    .CW     (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
`ifdef PROG_LOADER_CHECKSUM_EN
    .ld_chk    (ld_chk),
`endif
    .im_wr_en  (im_wr_en),
    .im_addr   (im_addr),
    .im_wr_data(im_wr_data),
    .core_reset(core_reset),
    .core_req  (core_req),
    .core_done (core_done),
    .busy      (busy),
    .run_done  (run_done),
    .err       (err),
    .err_code  (err_code),
    .prog_len  (prog_len),
    .cycles    (cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard comparisons at the falling edge, away from the active edge.
  initial begin : monitor
    logic prev_req, prev_done, prev_err;
    wr_t  w;
    res_t r;
    prev_req  = 1'b0;
    prev_done = 1'b0;
    prev_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (im_wr_en) begin
          if (wq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: addr %0h data %0h", im_addr, im_wr_data);
          end else begin
            w = wq.pop_front();
            check("wr_addr", 32'(im_addr), 32'(w.addr));
            check("wr_data", 32'(im_wr_data), 32'(w.data));
          end
        end
        if (core_req) begin
          req_cnt++;
          check("req_core_reset_low", 32'(core_reset), 32'd0);
          check("req_single_cycle", 32'(prev_req), 32'd0);
        end
        if ((run_done && !prev_done) || (err && !prev_err)) begin
          if (rq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: run_done %0b err %0b", run_done, err);
          end else begin
            r = rq.pop_front();
            check("res_err", 32'(err), 32'(r.is_err));
            check("res_run_done", 32'(run_done), 32'(!r.is_err));
            check("res_err_code", 32'(err_code), 32'(r.code));
            check("res_cycles", 32'(cycles), 32'(r.cyc));
            check("res_prog_len", 32'(prog_len), 32'(r.len));
          end
        end
      end
      prev_req  = core_req;
      prev_done = run_done;
      prev_err  = err;
    end
  end

  // Entered and left at posedge+1.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_ld_ready", 32'(ld_ready), 32'd1);
    check("start_err", 32'(err), 32'd0);
    check("start_err_code", 32'(err_code), 32'd0);
    check("start_run_done", 32'(run_done), 32'd0);
    check("start_prog_len", 32'(prog_len), 32'd0);
    check("start_core_reset", 32'(core_reset), 32'd1);
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic last, input int gap);
    for (int g = 0; g < gap; g++) begin
      ld_valid = 1'b0;
      ld_last  = 1'($urandom_range(0, 1));  // must be ignored without valid
      ld_data  = W'($urandom);
      @(posedge clk);
      #1;
    end
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    check("ld_ready_in_load", 32'(ld_ready), 32'd1);
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Loads prog[0..n-1] (8 words without last when ovf), then runs the core with done in
  // RUN cycle done_at (never when done_at > TO). chk_flip != 0 corrupts the checksum.
  task automatic run_prog(input int n, input bit ovf, input logic [W-1:0] chk_flip,
                          input int done_at, input int max_gap);
    int      cnt, req0, k;
    logic [W-1:0] xsum;
    res_t    r;
    bit      bad;
    cnt  = ovf ? 8 : n;
    xsum = '0;
    for (int i = 0; i < n; i++) xsum ^= prog[i];
`ifdef PROG_LOADER_CHECKSUM_EN
    ld_chk = xsum ^ chk_flip;
    bad    = (chk_flip != '0);
`else
    bad    = 1'b0;
`endif
    if (ovf) r = '{is_err: 1'b1, code: 2'd1, cyc: '0, len: (D+1)'(8)};
    else if (bad) r = '{is_err: 1'b1, code: 2'd3, cyc: '0, len: (D+1)'(n)};
    else if (done_at <= int'(TO)) r = '{is_err: 1'b0, code: 2'd0, cyc: CW'(done_at),
                                        len: (D+1)'(n)};
    else r = '{is_err: 1'b1, code: 2'd2, cyc: CW'(TO), len: (D+1)'(n)};
    rq.push_back(r);
    req0 = req_cnt;
    do_start();
    for (int i = 0; i < cnt; i++) begin
      wq.push_back('{addr: D'(i), data: prog[i]});
      send_word(prog[i], !ovf && (i == cnt - 1), $urandom_range(0, max_gap));
    end
    if (!ovf && !bad) begin
      // LAUNCH cycle: stream closed, core still in reset.
      check("launch_ld_ready", 32'(ld_ready), 32'd0);
      check("launch_core_reset", 32'(core_reset), 32'd1);
      @(posedge clk);
      #1;
      check("run1_core_req", 32'(core_req), 32'd1);
      if (done_at <= int'(TO)) begin
        repeat (done_at - 1) begin
          @(posedge clk);
          #1;
        end
        core_done = 1'b1;
        @(posedge clk);
        #1;
        core_done = 1'b0;
      end
    end
    k = 0;
    while (!(run_done || err) && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("end_reached", 32'(run_done || err), 32'd1);
    check("req_pulses", 32'(req_cnt - req0), (ovf || bad) ? 32'd0 : 32'd1);
    if (err) check("err_core_reset", 32'(core_reset), 32'd1);
    else check("finish_core_reset", 32'(core_reset), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    reset     = 1'b1;
    start     = 1'b0;
    ld_valid  = 1'b0;
    ld_data   = '0;
    ld_last   = 1'b0;
    core_done = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    ld_chk    = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_im_wr_en", 32'(im_wr_en), 32'd0);
    check("rst_im_addr", 32'(im_addr), 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_core_req", 32'(core_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", {29'd0, run_done, err, 1'b0}, 32'd0);
    check("rst_counts", {12'd0, 4'(prog_len), cycles}, 32'd0);

    // Directed: three words, done in RUN cycle 10.
    prog[0] = 9'h1A0;
    prog[1] = 9'h055;
    prog[2] = 9'h1FF;
    run_prog(3, 1'b0, '0, 10, 0);
    // Gapped stream.
    for (int i = 0; i < 5; i++) prog[i] = W'($urandom);
    run_prog(5, 1'b0, '0, 4, 3);
    // Overflow: eight words, no last.
    for (int i = 0; i < 8; i++) prog[i] = W'($urandom);
    run_prog(8, 1'b1, '0, 5, 1);
    // Timeout, then done on the very last budget cycle (done wins).
    run_prog(2, 1'b0, '0, 25, 0);
    run_prog(2, 1'b0, '0, int'(TO), 0);

    // Reset in RUN cycle 5.
    prog[0] = 9'h0AA;
    do_start();
    wq.push_back('{addr: '0, data: prog[0]});
    send_word(prog[0], 1'b1, 0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_core_reset", 32'(core_reset), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ctrl", {28'd0, ld_ready, im_wr_en, core_req, run_done}, 32'd0);
    check("midrst_err", {29'd0, err, err_code}, 32'd0);
    check("midrst_counts", {12'd0, 4'(prog_len), cycles}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

`ifdef PROG_LOADER_CHECKSUM_EN
    prog[0] = 9'h003;
    prog[1] = 9'h005;
    run_prog(2, 1'b0, 9'h000, 3, 0);  // ld_chk = 9'h006
    run_prog(2, 1'b0, 9'h001, 3, 0);  // ld_chk = 9'h007
`endif

    for (int t = 0; t < 20; t++) begin
      logic [W-1:0] flip;
      for (int i = 0; i < 8; i++) prog[i] = W'($urandom);
      flip = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      if ($urandom_range(0, 3) == 0) flip = W'($urandom_range(1, 511));
`endif
      run_prog($urandom_range(1, 8), ($urandom_range(0, 4) == 0), flip,
               $urandom_range(1, 24), $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    check("write_queue_drained", 32'(wq.size()), 32'd0);
    check("result_queue_drained", 32'(rq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
